// File: rtl/tx_frame_if.sv
// tx_frame_if: start/config, payload byte stream and symbol stream of the frame sequencer.
interface tx_frame_if;
    logic       start;
    logic [7:0] cfg_len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_I;
    logic       out_Q;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       underrun;
    modport master (
        output start, cfg_len, in_data, in_valid, out_ready,
        input  in_ready, out_I, out_Q, out_valid, busy, done, underrun
    );
    modport slave (
        input  start, cfg_len, in_data, in_valid, out_ready,
        output in_ready, out_I, out_Q, out_valid, busy, done, underrun
    );
endinterface

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: emits preamble, sync word, length and payload as 2-bit {I,Q} symbols, then a guard gap.
module tx_frame_sequencer #(
    parameter int          PREAMBLE_SYMS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hF3A0,
    parameter int          GUARD_CYCLES  = 32
) (
    input  logic      clk,
    input  logic      rst,
    tx_frame_if.slave bus
);
    localparam int CMAX0 = (PREAMBLE_SYMS > GUARD_CYCLES) ? PREAMBLE_SYMS : GUARD_CYCLES;
    localparam int CMAX  = (CMAX0 > 8) ? CMAX0 : 8;
    localparam int CW    = $clog2(CMAX);
    localparam logic [CW-1:0] PRE_LAST   = CW'(PREAMBLE_SYMS - 1);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(7);
    localparam logic [CW-1:0] QUAD_LAST  = CW'(3);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRE, SYNC, LEN, PAY, GUARD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    byte_q, byte_d;
    logic          full_q, full_d;
    logic [7:0]    fetched_q, fetched_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    logic        more, fire, take, last;
    logic [1:0]  sym;
    logic [15:0] sw;
    logic [7:0]  lw, bw;

    assign more          = fetched_q != len_q;
    assign bus.in_ready  = (state_q == PAY) && !full_q && more;
    assign bus.out_valid = (state_q == PRE) || (state_q == SYNC) || (state_q == LEN) || ((state_q == PAY) && full_q);
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;
    assign bus.underrun  = underrun_q;
    assign fire          = bus.out_valid && bus.out_ready;
    assign take          = bus.in_ready && bus.in_valid;

    // Each field is sent MSB first: shift the current pair into the top two bits.
    assign sw  = SYNC_WORD << {cnt_q[2:0], 1'b0};
    assign lw  = len_q << {cnt_q[1:0], 1'b0};
    assign bw  = byte_q << {cnt_q[1:0], 1'b0};
    assign sym = (state_q == PRE)  ? {~cnt_q[0], cnt_q[0]} :
                 (state_q == SYNC) ? sw[15:14] :
                 (state_q == LEN)  ? lw[7:6] : bw[7:6];
    assign {bus.out_I, bus.out_Q} = bus.out_valid ? sym : 2'b00;

    assign last = (state_q == PRE)   ? cnt_q == PRE_LAST :
                  (state_q == SYNC)  ? cnt_q == SYNC_LAST :
                  (state_q == GUARD) ? cnt_q == GUARD_LAST : cnt_q == QUAD_LAST;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        byte_d     = byte_q;
        full_d     = full_q;
        fetched_d  = fetched_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        if (take) begin
            byte_d    = bus.in_data;
            full_d    = 1'b1;
            fetched_d = fetched_q + 8'd1;
        end
        // A symbol is owed but nothing is loaded and nothing is arriving.
        if ((state_q == PAY) && !full_q && more && !bus.in_valid) underrun_d = 1'b1;
        if ((state_q != IDLE) && (fire || (state_q == GUARD))) cnt_d = last ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: if (bus.start && !done_q) begin
                state_d    = PRE;
                len_d      = bus.cfg_len;
                underrun_d = 1'b0;
                fetched_d  = '0;
            end
            PRE:  if (fire && last) state_d = SYNC;
            SYNC: if (fire && last) state_d = LEN;
            LEN:  if (fire && last) state_d = (len_q != 8'd0) ? PAY : GUARD;
            PAY:  if (fire && last) begin
                full_d = 1'b0;
                if (!more) state_d = GUARD;
            end
            GUARD: if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            byte_q     <= '0;
            full_q     <= 1'b0;
            fetched_q  <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            byte_q     <= byte_d;
            full_q     <= full_d;
            fetched_q  <= fetched_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: table-driven and randomized frames checked against a queue-based frame model.
module tb_tx_frame_sequencer;
    localparam int          PRE = 16;
    localparam logic [15:0] SW  = 16'hF3A0;
    localparam int          GC  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_frame_if bus();

    tx_frame_sequencer #(.PREAMBLE_SYMS(PRE), .SYNC_WORD(SW), .GUARD_CYCLES(GC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        int len;
        int rdy;
        int gap;
        bit noise;
        int exp_syms;
        bit exp_ur;
        bit gold;
    } vec_t;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [6:0] outs();
        return {bus.busy, bus.out_valid, bus.in_ready, bus.done, bus.underrun, bus.out_I, bus.out_Q};
    endfunction

    task automatic run_frame(input vec_t v);
        logic [1:0]  exp_q[$];
        logic [1:0]  got_q[$];
        logic [7:0]  data[$];
        logic [1:0]  s, prev;
        logic [71:0] packed_syms;
        int budget, consumed, unstable, gap_left, errs, extra;
        bit done_seen, stalled, busy_at_done, ur_at_done;
        if (v.gold) data = '{8'hC3, 8'h5A};
        else for (int i = 0; i < v.len; i++) data.push_back(8'($urandom));
        for (int k = 0; k < PRE; k++) exp_q.push_back((k % 2 == 0) ? 2'b10 : 2'b01);
        for (int j = 0; j < 8; j++) exp_q.push_back(2'(SW >> (14 - 2 * j)));
        for (int j = 0; j < 4; j++) exp_q.push_back(2'(v.len >> (6 - 2 * j)));
        foreach (data[i]) for (int j = 0; j < 4; j++) exp_q.push_back(2'(data[i] >> (6 - 2 * j)));
        budget = 200 + 6 * v.exp_syms + v.gap;
        consumed = 0; unstable = 0; gap_left = 0; done_seen = 0; stalled = 0;
        prev = 2'b00; busy_at_done = 1'b1; ur_at_done = 1'b0;
        bus.start = 1'b1;
        bus.cfg_len = 8'(v.len);
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_len = ~8'(v.len);
        chk("busy_after_start", bus.busy, 1);
        chk("underrun_cleared", bus.underrun, 0);
        chk("first_sym_latency", bus.out_valid, 1);
        for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
            s = {bus.out_I, bus.out_Q};
            if (stalled && (!bus.out_valid || s != prev)) unstable++;
            if (bus.done) begin
                done_seen = 1;
                busy_at_done = bus.busy;
                ur_at_done = bus.underrun;
            end
            bus.out_ready = (v.rdy == 0) ? 1'b1 : (v.rdy == 1) ? (cyc % 3 == 0) : 1'($urandom);
            bus.in_valid = gap_left == 0;
            bus.in_data = (consumed < data.size()) ? data[consumed] : 8'($urandom);
            bus.start = v.noise && (bus.done || ($urandom_range(0, 7) == 0));
            if (gap_left > 0) gap_left--;
            if (bus.out_valid && bus.out_ready) got_q.push_back(s);
            if (bus.in_ready && bus.in_valid) begin
                consumed++;
                if (consumed == 1) gap_left = v.gap;
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev = s;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy || bus.out_valid) extra++;
            @(negedge clk);
        end
        errs = 0;
        foreach (got_q[i]) if (i >= exp_q.size() || got_q[i] != exp_q[i]) errs++;
        chk("done_seen", done_seen, 1);
        chk("busy_low_with_done", busy_at_done, 0);
        chk("symbol_count", got_q.size(), v.exp_syms);
        chk("model_symbol_count", exp_q.size(), v.exp_syms);
        chk("symbol_errors", errs, 0);
        chk("bytes_consumed", consumed, v.len);
        chk("stall_unstable", unstable, 0);
        chk("underrun_flag", ur_at_done, v.exp_ur);
        chk("no_extra_frame", extra, 0);
        if (v.gold) begin
            packed_syms = '0;
            foreach (got_q[i]) packed_syms = {packed_syms[69:0], got_q[i]};
            chk("gold_sequence", packed_syms, 72'h9999_9999_F3A0_02C3_5A);
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        vecs[0] = '{len: 2,   rdy: 0, gap: 0,  noise: 0, exp_syms: 36,   exp_ur: 0, gold: 1};
        vecs[1] = '{len: 0,   rdy: 0, gap: 0,  noise: 0, exp_syms: 28,   exp_ur: 0, gold: 0};
        vecs[2] = '{len: 1,   rdy: 1, gap: 0,  noise: 0, exp_syms: 32,   exp_ur: 0, gold: 0};
        vecs[3] = '{len: 3,   rdy: 0, gap: 20, noise: 0, exp_syms: 40,   exp_ur: 1, gold: 0};
        vecs[4] = '{len: 2,   rdy: 0, gap: 0,  noise: 1, exp_syms: 36,   exp_ur: 0, gold: 0};
        vecs[5] = '{len: 255, rdy: 0, gap: 0,  noise: 0, exp_syms: 1048, exp_ur: 0, gold: 0};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cfg_len = 8'd0;
        bus.in_data = 8'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 7'd0);
        bus.start = 1'b1;
        bus.cfg_len = 8'd5;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_beats_start", outs(), 7'd0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        foreach (vecs[i]) run_frame(vecs[i]);
        bus.start = 1'b1;
        bus.cfg_len = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (32) @(negedge clk);
        chk("mid_pay_active", {bus.busy, bus.out_valid}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_pay_reset_outputs", outs(), 7'd0);
        rv = '{len: 1, rdy: 0, gap: 0, noise: 0, exp_syms: 32, exp_ur: 0, gold: 0};
        run_frame(rv);
        for (int i = 0; i < 6; i++) begin
            rv.len = $urandom_range(0, 8);
            rv.rdy = 2;
            rv.gap = 0;
            rv.noise = 1'($urandom);
            rv.exp_syms = PRE + 8 + 4 + 4 * rv.len;
            rv.exp_ur = 0;
            rv.gold = 0;
            run_frame(rv);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
